// File: rtl/inst_rom_sync.sv
// Loadable instruction memory for the LegV8 fetch path.
// Words are written through the program-load port; fetches use a valid/ready
// request, return one cycle later, and are held until the consumer accepts them.
// Words not loaded since reset, out-of-range fetches and misaligned byte
// addresses all return DEFAULT_WORD (BR XZR).
module inst_rom_sync #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DEPTH        = 1024,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 32'hD60003E0,
    parameter bit                    BYTE_ADDR    = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_fault,
    input  logic                  prog_en,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic [ADDR_WIDTH:0]   loaded_count
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];

    // Storage: the array itself is never reset; the loaded vector decides visibility.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      loaded_q, loaded_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_fault_q, rsp_fault_d;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_misaligned;
    logic                  req_in_range;
    logic                  req_fire;
    logic                  prog_in_range;
    logic                  prog_fire;
    logic [IDX_W-1:0]      prog_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_fault;

    // Loads win over fetches, so a read never races a write to the same word.
    assign req_ready     = reset && !prog_en && (!rsp_valid_q || rsp_ready);
    assign req_fire      = req_valid && req_ready;
    assign req_in_range  = ({1'b0, req_idx} < DEPTH_C);
    assign prog_in_range = ({1'b0, prog_addr} < DEPTH_C);
    assign prog_fire     = prog_en && prog_in_range;
    assign prog_idx      = prog_addr[IDX_W-1:0];
    assign rd_idx        = req_idx[IDX_W-1:0];

    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_fault    = rsp_fault_q;
    assign loaded_count = count_q;

    // Translate the request address into a word index and flag misalignment.
    always_comb begin
        req_idx        = req_addr;
        req_misaligned = 1'b0;
        if (BYTE_ADDR) begin
            req_idx        = {2'b00, req_addr[ADDR_WIDTH-1:2]};
            req_misaligned = (req_addr[1:0] != 2'b00);
        end
    end

    // Choose the response word: faults and unloaded words return DEFAULT_WORD.
    always_comb begin
        sel_data  = DEFAULT_WORD;
        sel_fault = 1'b0;
        if (req_misaligned || !req_in_range) begin
            sel_fault = 1'b1;
        end else if (loaded_q[rd_idx]) begin
            sel_data = mem_q[rd_idx];
        end
    end

    // Response register next state: capture on accept, clear once consumed.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        if (req_fire) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = sel_data;
            rsp_fault_d = sel_fault;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Loaded-bit and distinct-word counter next state; rewrites do not count.
    always_comb begin
        loaded_d = loaded_q;
        count_d  = count_q;
        if (prog_fire) begin
            loaded_d[prog_idx] = 1'b1;
            if (!loaded_q[prog_idx]) begin
                count_d = count_q + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= DEFAULT_WORD;
            rsp_fault_q <= 1'b0;
            loaded_q    <= '0;
            count_q     <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            loaded_q    <= loaded_d;
            count_q     <= count_d;
        end
    end

    // Array write; a load during reset is ignored.
    always_ff @(posedge clock) begin
        if (reset && prog_fire) begin
            mem_q[prog_idx] <= prog_data;
        end
    end

endmodule

// File: tb/tb_inst_rom_sync.sv
// Bench for inst_rom_sync: a word-indexed and a byte-addressed instance, both
// DEPTH=16. Fetch stimulus pushes the expected response into a queue when the
// request is accepted; a monitor pops and compares on each consumed response.
module tb_inst_rom_sync;

    localparam logic [31:0] DEF = 32'hD60003E0;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic [15:0] req_addr     [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_data     [2];
    logic        rsp_fault    [2];
    logic        prog_en      [2];
    logic [15:0] prog_addr    [2];
    logic [31:0] prog_data    [2];
    logic [16:0] loaded_count [2];

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    inst_rom_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(16),
                    .DEFAULT_WORD(DEF), .BYTE_ADDR(1'b0)) u_word (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_fault(rsp_fault[0]), .prog_en(prog_en[0]), .prog_addr(prog_addr[0]),
        .prog_data(prog_data[0]), .loaded_count(loaded_count[0])
    );

    inst_rom_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(16),
                    .DEFAULT_WORD(DEF), .BYTE_ADDR(1'b1)) u_byte (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_fault(rsp_fault[1]), .prog_en(prog_en[1]), .prog_addr(prog_addr[1]),
        .prog_data(prog_data[1]), .loaded_count(loaded_count[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int d, input logic [15:0] a, input logic [31:0] v);
        prog_en[d]   = 1'b1;
        prog_addr[d] = a;
        prog_data[d] = v;
        tick();
        prog_en[d] = 1'b0;
    endtask

    // Present a request, wait (bounded) for acceptance, push the expectation.
    task automatic fetch(input int d, input logic [15:0] a, input logic [31:0] v,
                         input logic f, output int waited);
        bit ok;
        exp_t e;
        ok        = 1'b0;
        waited    = 0;
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        while (!ok && waited <= 40) begin
            @(negedge clock);
            if (req_ready[d]) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout dut=%0d addr=%h req_ready stayed 0", d, a);
        end else begin
            e.dut   = d;
            e.data  = v;
            e.fault = f;
            sbq.push_back(e);
        end
        tick();
        req_valid[d] = 1'b0;
    endtask

    // Monitor: every consumed response must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (reset === 1'b1 && rsp_valid[d] === 1'b1 && rsp_ready[d] === 1'b1) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rsp dut=%0d actual=%h/%b required=none",
                             d, rsp_data[d], rsp_fault[d]);
                end else begin
                    e = sbq.pop_front();
                    if (e.dut != d || rsp_data[d] !== e.data || rsp_fault[d] !== e.fault) begin
                        bad++;
                        $display("FAIL rsp dut=%0d actual=%h/%b required dut=%0d %h/%b",
                                 d, rsp_data[d], rsp_fault[d], e.dut, e.data, e.fault);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = '0;
            rsp_ready[d] = 1'b1;
            prog_en[d]   = 1'b0;
            prog_addr[d] = '0;
            prog_data[d] = '0;
        end
        repeat (3) tick();

        // 1: reset state, then fetch of empty memory
        chk("reset_rsp_valid", rsp_valid[0], 0);
        chk("reset_rsp_data", rsp_data[0], DEF);
        chk("reset_rsp_fault", rsp_fault[0], 0);
        chk("reset_count", loaded_count[0], 0);
        chk("reset_req_ready", req_ready[0], 0);
        reset = 1'b1;
        tick();
        fetch(0, 16'd0, DEF, 1'b0, w);
        tick();
        chk("empty_count", loaded_count[0], 0);

        // 2: load four words, fetch back-to-back, reload one
        load(0, 16'd0, 32'h91019004);
        load(0, 16'd1, 32'hD2803208);
        load(0, 16'd2, 32'hD2809609);
        load(0, 16'd3, 32'hB40000C4);
        chk("count_after_4", loaded_count[0], 4);
        fetch(0, 16'd0, 32'h91019004, 1'b0, w); chk("b2b_wait0", w, 0);
        fetch(0, 16'd1, 32'hD2803208, 1'b0, w); chk("b2b_wait1", w, 0);
        fetch(0, 16'd2, 32'hD2809609, 1'b0, w); chk("b2b_wait2", w, 0);
        fetch(0, 16'd3, 32'hB40000C4, 1'b0, w); chk("b2b_wait3", w, 0);
        load(0, 16'd2, 32'hAAAA5555);
        chk("count_after_reload", loaded_count[0], 4);

        // 3: backpressure holds the response and blocks new requests
        rsp_ready[0] = 1'b0;
        fetch(0, 16'd1, 32'hD2803208, 1'b0, w);
        fork
            fetch(0, 16'd2, 32'hAAAA5555, 1'b0, w2);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clock);
                    chk("hold_valid", rsp_valid[0], 1);
                    chk("hold_data", rsp_data[0], 32'hD2803208);
                    chk("hold_ready", req_ready[0], 0);
                end
                tick();
                rsp_ready[0] = 1'b1;
            end
        join
        tick();
        tick();

        // 4: range boundaries on the word-indexed instance
        fetch(0, 16'd16, DEF, 1'b1, w);
        fetch(0, 16'd15, DEF, 1'b0, w);
        load(0, 16'd20, 32'h12345678);
        chk("count_oor_load", loaded_count[0], 4);
        fetch(0, 16'd4, DEF, 1'b0, w);
        load(0, 16'd15, 32'h0F0F0F0F);
        chk("count_last_word", loaded_count[0], 5);
        fetch(0, 16'd15, 32'h0F0F0F0F, 1'b0, w);
        tick();
        tick();

        // 5: program load blocks fetches
        prog_en[0]   = 1'b1;
        prog_addr[0] = 16'd5;
        prog_data[0] = 32'h00000055;
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'd5;
        @(negedge clock);
        chk("prog_blocks_ready", req_ready[0], 0);
        tick();
        chk("prog_no_rsp", rsp_valid[0], 0);
        @(negedge clock);
        chk("prog_blocks_ready2", req_ready[0], 0);
        tick();
        chk("prog_no_rsp2", rsp_valid[0], 0);
        chk("count_prog_held", loaded_count[0], 6);
        prog_en[0] = 1'b0;
        fetch(0, 16'd5, 32'h00000055, 1'b0, w);
        chk("after_prog_wait", w, 0);
        tick();
        tick();

        // 6: reset drops a held response and forgets loaded words
        rsp_ready[0] = 1'b0;
        fetch(0, 16'd0, 32'h91019004, 1'b0, w);
        chk("pre_reset_valid", rsp_valid[0], 1);
        reset = 1'b0;
        tick();
        chk("post_reset_valid", rsp_valid[0], 0);
        chk("post_reset_data", rsp_data[0], DEF);
        chk("post_reset_count", loaded_count[0], 0);
        sbq.delete();
        reset        = 1'b1;
        rsp_ready[0] = 1'b1;
        tick();
        fetch(0, 16'd0, DEF, 1'b0, w);
        fetch(0, 16'd2, DEF, 1'b0, w);
        tick();
        tick();

        // Byte-addressed instance: alignment and range
        load(1, 16'd2, 32'h11112222);
        chk("byte_count", loaded_count[1], 1);
        fetch(1, 16'h0006, DEF, 1'b1, w);
        fetch(1, 16'h0008, 32'h11112222, 1'b0, w);
        fetch(1, 16'h0004, DEF, 1'b0, w);
        fetch(1, 16'h0040, DEF, 1'b1, w);
        tick();
        tick();
        chk("queue_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_rom_sync.md
Name: inst_rom_sync

Overview:
Parametrised, synchronous, loadable instruction memory for the LegV8 fetch path. It replaces fixed hard-coded program words with:
- a depth- and width-configurable array, filled through a program-load port;
- a registered read with valid/ready request and response handshakes;
- out-of-range and misalignment fault reporting.
Any word not loaded since reset reads as DEFAULT_WORD (BR XZR), so execution of empty memory stays trapped at address 0.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
ADDR_WIDTH, 16, width of req_addr and prog_addr
DEPTH, 1024, number of words stored (1..2^ADDR_WIDTH)
DEFAULT_WORD, 32'hD60003E0, word returned for unloaded, out-of-range or misaligned fetches
BYTE_ADDR, 0, 0: req_addr is a word index; 1: req_addr is a byte address (word index = req_addr>>2)

Ports:
clock  input  1  sole clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
req_valid  input  1  fetch request present
req_ready  output  1  fetch request can be accepted this cycle
req_addr  input  ADDR_WIDTH  fetch address
rsp_valid  output  1  rsp_data/rsp_fault valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_WIDTH  fetched instruction word
rsp_fault  output  1  fetch was out of range or misaligned
prog_en  input  1  write prog_data at prog_addr this cycle
prog_addr  input  ADDR_WIDTH  word index for program load (BYTE_ADDR does not apply)
prog_data  input  DATA_WIDTH  word to load
loaded_count  output  ADDR_WIDTH+1  number of distinct words loaded since reset

Behaviour:
- Reset (reset==0 at a clock edge):
  - rsp_valid=0, rsp_data=DEFAULT_WORD, rsp_fault=0, loaded_count=0.
  - All per-word loaded bits cleared. Array contents are not cleared but are unobservable until reloaded.
  - A pending response is dropped, and any prog_en asserted in the same cycle is ignored.
- Storage: DEPTH x DATA_WIDTH array, plus a DEPTH-bit loaded vector.
- Program load: prog_en=1 and prog_addr<DEPTH writes the word and sets its loaded bit at the edge.
  - loaded_count increments only when that bit was previously 0; a rewrite of the same word does not count.
  - prog_addr>=DEPTH: write ignored, no count change.
- req_ready = reset && !prog_en && (!rsp_valid || rsp_ready). Loads take priority, so no read/write hazard in the same cycle.
- Request is accepted when req_valid && req_ready. At the next edge: rsp_valid=1 and rsp_data/rsp_fault are registered. Latency is 1 cycle; throughput is 1 per cycle while rsp_ready=1.
- Index: idx = BYTE_ADDR ? req_addr[ADDR_WIDTH-1:2] : req_addr.
- Response selection:
  - BYTE_ADDR=1 and req_addr[1:0]!=0: fault=1, data=DEFAULT_WORD.
  - Else idx>=DEPTH: fault=1, data=DEFAULT_WORD.
  - Else loaded[idx]==0: fault=0, data=DEFAULT_WORD.
  - Else: fault=0, data=mem[idx].
- Hold: while rsp_valid && !rsp_ready, rsp_data and rsp_fault are stable and no new request is accepted.
- Completion without a new accept: when rsp_valid && rsp_ready and no new request is accepted, rsp_valid clears next cycle. rsp_data holds its last value.
- Load then fetch: a word written at edge N is returned by a request accepted at edge N+1 or later.
- A load while a response is held does not alter the held response, even for the same address.
- Fault is informational only; it does not alter flow control.

Test Plan:
1. Reset, then request addr 0 with rsp_ready=1 -> one cycle later rsp_valid=1, rsp_data=32'hD60003E0, rsp_fault=0; loaded_count=0.
2. Load addr 0..3 with 0x91019004, 0xD2803208, 0xD2809609, 0xB40000C4, then fetch 0..3 back-to-back -> data in order on 4 consecutive cycles, req_ready held 1, loaded_count=4. Reload addr 2 -> count stays 4.
3. Issue requests to addr 1 and 2 with rsp_ready=0 for 3 cycles -> addr 1 response held stable and req_ready=0; on release, addr 1 then addr 2 delivered with none lost or duplicated.
4. DEPTH=16: fetch addr 16 -> fault=1, data DEFAULT_WORD. prog_en at addr 20 -> ignored, count unchanged. BYTE_ADDR=1: fetch addr 0x6 -> fault=1; fetch 0x8 -> mem[2].
5. Hold prog_en=1 with req_valid=1 -> req_ready=0, no response generated. Drop prog_en -> request accepted next cycle.
6. Assert reset while rsp_valid=1 with loaded words -> rsp_valid=0 next cycle; a subsequent fetch of a previously loaded address returns DEFAULT_WORD and loaded_count=0.
